// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers used by the MixColumns datapath.
package aes_pkg;

  localparam logic [7:0] AES_GF_POLY = 8'h1B;

  typedef logic [7:0]   aes_byte_t;
  typedef logic [31:0]  aes_col_t;
  typedef logic [127:0] aes_state_t;

  typedef enum logic [1:0] {
    MC_IDLE = 2'd0,
    MC_MIX  = 2'd1,
    MC_OUT  = 2'd2
  } mc_state_e;

  function automatic aes_byte_t xtime(input aes_byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_GF_POLY : 8'h00);
  endfunction

  // Only the constants of the forward and inverse matrices are needed; 1 falls to default.
  function automatic aes_byte_t gf_mul_const(input aes_byte_t b, input logic [3:0] k);
    aes_byte_t x2, x4, x8, r;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    case (k)
      4'd2:    r = x2;
      4'd3:    r = x2 ^ b;
      4'd9:    r = x8 ^ b;
      4'd11:   r = x8 ^ x2 ^ b;
      4'd13:   r = x8 ^ x4 ^ b;
      4'd14:   r = x8 ^ x4 ^ x2;
      default: r = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes_mix_column.sv
// Combinational single-column mixer: forward MixColumns or InvMixColumns.
module aes_mix_column
  import aes_pkg::*;
(
  input  aes_col_t col_i,
  input  logic     inv_i,
  output aes_col_t col_o
);

  aes_byte_t  a    [4];
  aes_byte_t  r    [4];
  logic [3:0] coef [4];
  logic [1:0] sel;

  // Row i uses the base coefficient row rotated right by i.
  always_comb begin
    sel = '0;
    for (int j = 0; j < 4; j++) a[j] = col_i[31-8*j -: 8];
    if (inv_i) coef = '{4'd14, 4'd11, 4'd13, 4'd9};
    else       coef = '{4'd2,  4'd3,  4'd1,  4'd1};
    for (int i = 0; i < 4; i++) begin
      r[i] = '0;
      for (int j = 0; j < 4; j++) begin
        sel  = 2'(j - i);
        r[i] = r[i] ^ gf_mul_const(a[j], coef[sel]);
      end
    end
  end

  assign col_o = {r[0], r[1], r[2], r[3]};

endmodule

// File: rtl/aes_mixcol_ctrl.sv
// Column-serial MixColumns sequencer: accepts one state, mixes it in place
// COLS_PER_CYCLE columns at a time, then holds the result for the consumer.
module aes_mixcol_ctrl
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  aes_state_t in_state,
  input  logic       in_inv,
  input  logic       in_bypass,
  output logic       out_valid,
  input  logic       out_ready,
  output aes_state_t out_state,
  output logic       busy,
  output logic [1:0] dbg_state
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("aes_mixcol_ctrl: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);

  mc_state_e  state_q,   state_d;
  logic [1:0] col_cnt_q, col_cnt_d;
  aes_state_t work_q,    work_d;
  logic       inv_q,     inv_d;

  logic [1:0] col_idx [COLS_PER_CYCLE];
  aes_col_t   mix_in  [COLS_PER_CYCLE];
  aes_col_t   mix_out [COLS_PER_CYCLE];

  // Column c sits at bits [127-32c -: 32]; 127-32c == {~c, 5'h1f} for 2-bit c.
  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_mixer
    assign col_idx[g] = col_cnt_q + 2'(g);
    assign mix_in[g]  = work_q[{~col_idx[g], 5'h1f} -: 32];
    aes_mix_column u_mix (
      .col_i (mix_in[g]),
      .inv_i (inv_q),
      .col_o (mix_out[g])
    );
  end

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid never depends on ready, and out_state holds while out_valid && !out_ready.
  always_comb begin
    state_d   = state_q;
    col_cnt_d = col_cnt_q;
    work_d    = work_q;
    inv_d     = inv_q;
    case (state_q)
      MC_IDLE: begin
        if (in_valid && in_ready) begin
          work_d    = in_state;
          inv_d     = in_inv;
          col_cnt_d = '0;
          state_d   = in_bypass ? MC_OUT : MC_MIX;
        end
      end
      MC_MIX: begin
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
          work_d[{~col_idx[g], 5'h1f} -: 32] = mix_out[g];
        end
        col_cnt_d = col_cnt_q + COL_STEP;
        if (col_cnt_q == LAST_COL) state_d = MC_OUT;
      end
      MC_OUT: begin
        if (out_ready) state_d = MC_IDLE;
      end
      default: state_d = MC_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= MC_IDLE;
      col_cnt_q <= '0;
      work_q    <= '0;
      inv_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_cnt_q <= col_cnt_d;
      work_q    <= work_d;
      inv_q     <= inv_d;
    end
  end

  assign in_ready  = (state_q == MC_IDLE) && !rst;
  assign out_valid = (state_q == MC_OUT);
  assign busy      = (state_q != MC_IDLE);
  assign out_state = work_q;
  assign dbg_state = state_q;

endmodule

// File: doc/aes_mixcol_ctrl.md
# aes_mixcol_ctrl

Column-serial sequencer for the AES MixColumns step. It accepts one 128-bit AES state over a valid/ready handshake and drives a shared column-mixer datapath over the state's four columns, COLS_PER_CYCLE columns per cycle. It supports forward MixColumns, InvMixColumns, and a last-round bypass, and presents the result over a valid/ready handshake. It sits between the ShiftRows stage and AddRoundKey in the round pipeline.

## Interface
- COLS_PER_CYCLE, 1: number of columns mixed per cycle; legal values are 1, 2 and 4; any other value is an elaboration error.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input state is valid.
- in_ready  out  1  block can accept; defined as state==IDLE && !rst.
- in_state  in  128  AES state; [127:120] = byte 0, column c = bytes 4c..4c+3, byte 4c is row 0 (FIPS-197 column-major).
- in_inv  in  1  1 = InvMixColumns, 0 = MixColumns; sampled at accept.
- in_bypass  in  1  1 = final round, output = input unmodified; sampled at accept.
- out_valid  out  1  out_state is valid.
- out_ready  in  1  downstream accepts.
- out_state  out  128  result, same byte layout as in_state.
- busy  out  1  high in MIX and OUT states.

## Operation
- FSM states: IDLE, MIX, OUT.
- IDLE, on in_valid && in_ready:
  - capture in_state into the working register; latch in_inv.
  - if in_bypass, go to OUT; else go to MIX with col_cnt = 0.
- MIX: each cycle, replace columns col_cnt .. col_cnt+COLS_PER_CYCLE-1 of the working register with the mixer output. col_cnt then advances by COLS_PER_CYCLE. After the cycle that processes column 3, go to OUT.
- Forward mix matrix rows: {02,03,01,01} rotated. Inverse matrix rows: {0e,0b,0d,09} rotated. Arithmetic is GF(2^8) modulo x^8+x^4+x^3+x+1 (reduction constant 8'h1B). Every product is 8 bits; there is no carry out.
- OUT:
  - out_valid = 1; out_state = working register.
  - hold out_state stable while out_ready = 0.
  - on out_valid && out_ready, return to IDLE.
- Inputs in_valid, in_state, in_inv and in_bypass are ignored outside IDLE.
- Reset:
  - in any state, rst forces IDLE and clears col_cnt, the working register and the latched flags.
  - reset values: in_ready = 0, out_valid = 0, busy = 0, out_state = 0.
  - reset mid-MIX discards the partial state; no output is produced.
- out_state is driven from the working register at all times. It is valid only when out_valid = 1.

## Timing
- Let N = 4/COLS_PER_CYCLE. Accept edge is E0.
- Mixed path: out_valid rises after edge EN, i.e. N cycles of latency (4 by default).
- Bypass path: out_valid rises after E0, i.e. 1 cycle of latency.
- in_ready rises the cycle after the output handshake edge. Minimum initiation interval is N+2 cycles for the mixed path and 3 cycles for bypass.
- in_valid asserted during reset is not accepted. in_ready = 1 on the first cycle with rst = 0.
- out_ready = 1 held continuously: out_valid is high for exactly one cycle per block.

## Structure
- Shared package aes_pkg holds:
  - constant AES_GF_POLY = 8'h1B
  - typedefs: aes_byte_t (8 bits), aes_col_t (32 bits), aes_state_t (128 bits)
  - functions: xtime and gf_mul_const for constants 2, 3, 9, 11, 13, 14
- One sub-module, aes_mix_column: a purely combinational 32-bit column mixer with an inv select.
- The controller instantiates COLS_PER_CYCLE copies of aes_mix_column, selected from the working register by col_cnt.
- The controller owns the FSM, col_cnt, the working register and the handshakes.

## Test plan
- Forward, COLS_PER_CYCLE=1: in_state = db135345_f20a225c_01010101_c6c6c6c6 -> out_state = 8e4da1bc_9fdc589d_01010101_c6c6c6c6, with out_valid rising 4 cycles after accept.
- Inverse: in_inv=1, in_state = 8e4da1bc_9fdc589d_d4d4d4d5_2d26314c -> out_state = db135345_f20a225c with the expected inverse columns for the last two. Bench checks round trip: inverse(forward(x)) = x over 1000 random states.
- Bypass: in_bypass=1, random state -> identical out_state, out_valid 1 cycle after accept, busy high for exactly 1 cycle.
- Backpressure: out_ready = 0 for 10 cycles -> out_valid and out_state stable for 10 cycles, in_ready = 0 throughout; out_ready = 1 -> in_ready = 1 the next cycle.
- Reset mid-MIX: rst pulsed after 2 column cycles -> out_valid never asserts, in_ready = 1 the cycle after rst falls. The next block, column d4d4d4d5 -> d5d5d7d6, is correct.
- Parameter sweep COLS_PER_CYCLE = 2 and 4: the forward vector gives identical results with latency 2 and 1; back-to-back blocks achieve initiation intervals of 4 and 3.
